// File: rtl/branch_stall_ctrl.sv
// Branch load-use stall controller.
// Stalls an ID-stage branch whose source operands are produced by a load
// still in EX (two stall cycles) or MEM (one stall cycle). ALU results are
// assumed forwarded and never stall. Keeps a saturating stall-cycle counter.
module branch_stall_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_Enable,
    input  logic        i_ID_Branch,
    input  logic        i_ID_UsesRt,
    input  logic [4:0]  i_Rs,
    input  logic [4:0]  i_Rt,
    input  logic        i_Taken,
    input  logic        i_IDEX_RegWrite,
    input  logic        i_IDEX_MemRead,
    input  logic [4:0]  i_IDEX_RegisterRD,
    input  logic        i_EXMEM_RegWrite,
    input  logic        i_EXMEM_MemRead,
    input  logic [4:0]  i_EXMEM_RegisterRD,
    input  logic        i_ClearCount,
    output logic        o_PCWrite,
    output logic        o_IFID_Write,
    output logic        o_IDEX_Bubble,
    output logic        o_IFID_Flush,
    output logic        o_Stalled,
    output logic [15:0] o_StallCount
);

    typedef enum logic {
        IDLE   = 1'b0,
        STALL1 = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem;
    logic haz_ex, haz_mem;
    logic stall;

    // Source/destination matches; register 0 never carries a dependency.
    always_comb begin
        rs_ex  = (i_Rs != 5'd0) && (i_Rs == i_IDEX_RegisterRD);
        rt_ex  = i_ID_UsesRt && (i_Rt != 5'd0) && (i_Rt == i_IDEX_RegisterRD);
        rs_mem = (i_Rs != 5'd0) && (i_Rs == i_EXMEM_RegisterRD);
        rt_mem = i_ID_UsesRt && (i_Rt != 5'd0) && (i_Rt == i_EXMEM_RegisterRD);
        haz_ex  = i_ID_Branch && i_IDEX_MemRead && i_IDEX_RegWrite && (rs_ex || rt_ex);
        haz_mem = i_ID_Branch && i_EXMEM_MemRead && i_EXMEM_RegWrite && (rs_mem || rt_mem);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pipeline control outputs.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        o_PCWrite     = 1'b0;
        o_IFID_Write  = 1'b0;
        o_IDEX_Bubble = 1'b0;
        o_IFID_Flush  = 1'b0;
        o_Stalled     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (haz_ex) begin
                    stall   = 1'b1;
                    state_d = STALL1;
                end else if (haz_mem) begin
                    stall   = 1'b1;
                end
            end
            STALL1: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!i_Enable) begin
            // Pipeline frozen: hold state, drive every control low.
            state_d = state_q;
        end else begin
            o_PCWrite     = !stall;
            o_IFID_Write  = !stall;
            o_IDEX_Bubble = stall;
            o_Stalled     = stall;
            o_IFID_Flush  = !stall && i_ID_Branch && i_Taken;
        end
    end

    // Stall counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (i_ClearCount) begin
            count_d = '0;
        end else if (i_Enable && stall && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_StallCount = count_q;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Directed testbench for branch_stall_ctrl.
module tb_branch_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        br;
    logic        uses_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        taken;
    logic        ex_rw;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        mem_rw;
    logic        mem_mr;
    logic [4:0]  mem_rd;
    logic        clr;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic        flush;
    logic        stalled;
    logic [15:0] cnt;

    int unsigned n_checks;
    int unsigned n_fail;

    // Output vector order: {PCWrite, IFID_Write, Bubble, Flush, Stalled}
    localparam logic [4:0] RUN   = 5'b11000;
    localparam logic [4:0] RUNFL = 5'b11010;
    localparam logic [4:0] STALL = 5'b00101;
    localparam logic [4:0] OFF   = 5'b00000;

    logic [4:0] outs;
    assign outs = {pcw, ifw, bub, flush, stalled};

    branch_stall_ctrl dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_Enable           (en),
        .i_ID_Branch        (br),
        .i_ID_UsesRt        (uses_rt),
        .i_Rs               (rs),
        .i_Rt               (rt),
        .i_Taken            (taken),
        .i_IDEX_RegWrite    (ex_rw),
        .i_IDEX_MemRead     (ex_mr),
        .i_IDEX_RegisterRD  (ex_rd),
        .i_EXMEM_RegWrite   (mem_rw),
        .i_EXMEM_MemRead    (mem_mr),
        .i_EXMEM_RegisterRD (mem_rd),
        .i_ClearCount       (clr),
        .o_PCWrite          (pcw),
        .o_IFID_Write       (ifw),
        .o_IDEX_Bubble      (bub),
        .o_IFID_Flush       (flush),
        .o_Stalled          (stalled),
        .o_StallCount       (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet();
        en = 1'b1; br = 1'b0; uses_rt = 1'b0; rs = 5'd0; rt = 5'd0; taken = 1'b0;
        ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
        mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = 5'd0; clr = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between edges; returns at posedge+1.
    task automatic do_reset();
        quiet();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        #7;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    // Load $t1(9) in EX, beq $t1,$t2(10): two stall cycles.
    task automatic test_ex_load();
        do_reset();
        br = 1'b1; uses_rt = 1'b1; rs = 5'd9; rt = 5'd10;
        ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd9;
        #2;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL ex_stall1: got %b expected %b", outs, STALL); end
        tick();
        ex_rw = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
        #2;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL ex_stall2: got %b expected %b", outs, STALL); end
        n_checks++;
        if (cnt !== 16'd1) begin n_fail++; $display("FAIL ex_count_mid: got %h expected 0001", cnt); end
        tick();
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL ex_release: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd2) begin n_fail++; $display("FAIL ex_count: got %h expected 0002", cnt); end
        quiet();
        tick();
    endtask

    // Load $t1 in MEM only, bne $t1: one stall cycle.
    task automatic test_mem_load();
        do_reset();
        br = 1'b1; uses_rt = 1'b1; rs = 5'd9; rt = 5'd3;
        mem_rw = 1'b1; mem_mr = 1'b1; mem_rd = 5'd9;
        #2;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL mem_stall: got %b expected %b", outs, STALL); end
        tick();
        mem_rw = 1'b0; mem_mr = 1'b0; mem_rd = 5'd0;
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL mem_release: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd1) begin n_fail++; $display("FAIL mem_count: got %h expected 0001", cnt); end
        quiet();
        tick();
    endtask

    // ALU producer in EX, taken branch: no stall, one-cycle flush.
    task automatic test_alu_taken();
        do_reset();
        br = 1'b1; uses_rt = 1'b1; rs = 5'd9; rt = 5'd10; taken = 1'b1;
        ex_rw = 1'b1; ex_mr = 1'b0; ex_rd = 5'd9;
        #2;
        n_checks++;
        if (outs !== RUNFL) begin n_fail++; $display("FAIL alu_flush: got %b expected %b", outs, RUNFL); end
        tick();
        quiet();
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL alu_after: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL alu_count: got %h expected 0000", cnt); end
        tick();
    endtask

    // $zero never matches; rt ignored unless UsesRt; taken ignored while stalling.
    task automatic test_match_rules();
        do_reset();
        br = 1'b1; uses_rt = 1'b1; rs = 5'd0; rt = 5'd0;
        ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd0;
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL zero_reg: got %b expected %b", outs, RUN); end
        uses_rt = 1'b0; rs = 5'd3; rt = 5'd5; ex_rd = 5'd5;
        #1;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL rt_unused: got %b expected %b", outs, RUN); end
        uses_rt = 1'b1; taken = 1'b1;
        #1;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL rt_used_noflush: got %b expected %b", outs, STALL); end
        quiet();
        tick();
        tick();
    endtask

    // Reset pulse while in STALL1 aborts the pending stall.
    task automatic test_reset_in_stall();
        do_reset();
        br = 1'b1; rs = 5'd7; ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd7;
        tick();
        quiet();
        #2;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL rst_pre_stall1: got %b expected %b", outs, STALL); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL rst_abort_outs: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL rst_abort_count: got %h expected 0000", cnt); end
        rst_n = 1'b1;
        tick();
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL rst_after: got %b expected %b", outs, RUN); end
        tick();
    endtask

    // Enable low during STALL1 holds state and count; clear still honoured.
    task automatic test_enable_hold();
        do_reset();
        br = 1'b1; rs = 5'd7; ex_rw = 1'b1; ex_mr = 1'b1; ex_rd = 5'd7;
        tick();
        quiet();
        en = 1'b0;
        #2;
        n_checks++;
        if (outs !== OFF) begin n_fail++; $display("FAIL dis_outs: got %b expected %b", outs, OFF); end
        tick(); tick(); tick();
        n_checks++;
        if (cnt !== 16'd1) begin n_fail++; $display("FAIL dis_count_hold: got %h expected 0001", cnt); end
        en = 1'b1;
        #1;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL dis_resume_stall: got %b expected %b", outs, STALL); end
        tick();
        #2;
        n_checks++;
        if (outs !== RUN) begin n_fail++; $display("FAIL dis_resume_idle: got %b expected %b", outs, RUN); end
        n_checks++;
        if (cnt !== 16'd2) begin n_fail++; $display("FAIL dis_count: got %h expected 0002", cnt); end
        en = 1'b0; clr = 1'b1;
        tick();
        n_checks++;
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL dis_clear: got %h expected 0000", cnt); end
        quiet();
        tick();
    endtask

    // Continuous MEM-load hazard stalls every cycle: drive count to saturation.
    task automatic test_saturation();
        do_reset();
        br = 1'b1; rs = 5'd4; mem_rw = 1'b1; mem_mr = 1'b1; mem_rd = 5'd4;
        for (int i = 0; i < 65534; i++) tick();
        n_checks++;
        if (cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", cnt); end
        tick(); tick(); tick();
        n_checks++;
        if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_nowrap: got %h expected ffff", cnt); end
        clr = 1'b1;
        #1;
        n_checks++;
        if (outs !== STALL) begin n_fail++; $display("FAIL clr_stall: got %b expected %b", outs, STALL); end
        tick();
        n_checks++;
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL clr_wins: got %h expected 0000", cnt); end
        quiet();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ex_load();
        test_mem_load();
        test_alu_taken();
        test_match_rules();
        test_reset_in_stall();
        test_enable_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_stall_ctrl.md
BRANCH_STALL_CTRL -- requirements
Module: branch_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be as listed below.
REQ-002 The block SHALL have the following ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_Enable  input  1  pipeline advance enable from debug/step logic
- i_ID_Branch  input  1  branch/jr in ID that compares rs (and rt)
- i_ID_UsesRt  input  1  ID branch reads rt (beq/bne)
- i_Rs  input  5  ID rs field
- i_Rt  input  5  ID rt field
- i_Taken  input  1  branch comparator result, forwarded operands
- i_IDEX_RegWrite  input  1  EX-stage instruction writes a register
- i_IDEX_MemRead  input  1  EX-stage instruction is a load
- i_IDEX_RegisterRD  input  5  EX-stage destination
- i_EXMEM_RegWrite  input  1  MEM-stage instruction writes a register
- i_EXMEM_MemRead  input  1  MEM-stage instruction is a load
- i_EXMEM_RegisterRD  input  5  MEM-stage destination
- i_ClearCount  input  1  synchronous clear of stall counter
- o_PCWrite  output  1  PC update enable
- o_IFID_Write  output  1  IF/ID register write enable
- o_IDEX_Bubble  output  1  insert NOP into ID/EX
- o_IFID_Flush  output  1  squash instruction in IF/ID (taken branch)
- o_Stalled  output  1  high in any stall cycle
- o_StallCount  output  16  saturating count of stall cycles

Function
REQ-003 The block SHALL detect only hazards that forwarding cannot resolve (loads); ALU producers in EX, MEM and WB SHALL NOT cause a stall.
REQ-004 A source matches a destination only if the register numbers are equal and nonzero; rt SHALL be compared only when i_ID_UsesRt=1.
REQ-005 haz_ex SHALL be i_ID_Branch & i_IDEX_MemRead & i_IDEX_RegWrite & (rs or rt matches i_IDEX_RegisterRD).
REQ-006 haz_mem SHALL be i_ID_Branch & i_EXMEM_MemRead & i_EXMEM_RegWrite & (rs or rt matches i_EXMEM_RegisterRD).
REQ-007 The FSM SHALL have two states: IDLE and STALL1.
REQ-008 In IDLE with haz_ex: stall this cycle; next state STALL1 (two stall cycles in total).
REQ-009 In IDLE with haz_mem and no haz_ex: stall this cycle; next state IDLE (one stall cycle in total).
REQ-010 In IDLE with no hazard: no stall; next state IDLE.
REQ-011 In STALL1: stall unconditionally, inputs ignored; next state IDLE, where detection runs again.
REQ-012 In a stall cycle: o_PCWrite=0, o_IFID_Write=0, o_IDEX_Bubble=1, o_IFID_Flush=0, o_Stalled=1.
REQ-013 In a non-stall cycle: o_PCWrite=1, o_IFID_Write=1, o_IDEX_Bubble=0, o_Stalled=0, o_IFID_Flush=i_ID_Branch & i_Taken.
REQ-014 i_Taken SHALL be ignored in stall cycles; a flush SHALL never coincide with a stall.
REQ-015 With i_Enable=0: o_PCWrite, o_IFID_Write, o_IDEX_Bubble, o_IFID_Flush and o_Stalled SHALL be 0; FSM state and counter SHALL hold; i_ClearCount is still honoured.
REQ-016 o_StallCount SHALL increment by 1 on each enabled stall cycle and saturate at 0xFFFF without wrap.
REQ-017 If i_ClearCount and a stall occur in the same cycle, the clear SHALL win and the count SHALL be 0.
REQ-018 All outputs except o_StallCount SHALL be combinational from the state and inputs, with zero-cycle latency.

Reset
REQ-019 i_rst_n=0 SHALL immediately force state=IDLE and o_StallCount=0, regardless of i_clk.
REQ-020 While in reset, outputs SHALL follow the IDLE rules.
REQ-021 Reset asserted in STALL1 SHALL abort the pending stall cycle.
REQ-022 After reset release, the first clock edge SHALL evaluate detection normally.

Verification
REQ-023 Load $t1 in EX, beq $t1,$t2 in ID -> two cycles with PCWrite=0 and Bubble=1, then PCWrite=1; StallCount=2.
REQ-024 Load $t1 in MEM only, bne $t1 in ID -> exactly one stall cycle; StallCount=1.
REQ-025 ALU add $t1 in EX, beq $t1 in ID with i_Taken=1 -> no stall; o_IFID_Flush=1 for one cycle.
REQ-026 Load $zero (rd=0) in EX, branch rs=0 -> no stall; load rd=5, branch with rt=5 and i_ID_UsesRt=0 -> no stall.
REQ-027 i_rst_n pulsed low in STALL1 -> outputs return to IDLE values immediately with StallCount=0; and, separately, i_Enable=0 during STALL1 for 3 cycles -> state held, then one stall cycle once enabled.
REQ-028 Preload the count to 0xFFFE and stall for 3 cycles -> count 0xFFFF with no wrap; assert i_ClearCount together with a stall -> count 0.
